// File: rtl/avgpool_if.sv
// Handshake and RAM-port bundle for the 2x2 average-pooling sequencer.
// The master side is the sequencer; the slave side is the surrounding buffers and control.
interface avgpool_if #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_W    = 10
);
  logic                        start;
  logic                        busy;
  logic                        done;
  logic [ADDR_W-1:0]           rd_addr;
  logic signed [WORD_SIZE-1:0] rd_data;
  logic                        wr_en;
  logic [ADDR_W-1:0]           wr_addr;
  logic signed [WORD_SIZE-1:0] wr_data;

  modport master (
    input  start, rd_data,
    output busy, done, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, rd_data,
    input  busy, done, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/avgpool_seq.sv
// 2x2 average-pooling sequencer: reads each window through a synchronous RAM port and writes one average per window.
// Build option AVGPOOL_ROUND_EN: round half up instead of flooring.
//
// state | meaning
// IDLE  | waiting for start
// RD0   | rd_addr = a0 (top-left of the window)
// RD1   | rd_addr = a1, capture a0 data
// RD2   | rd_addr = b0, accumulate a1 data
// RD3   | rd_addr = b1, accumulate b0 data
// WR    | add b1 data, write the pooled word, advance the window
// DONE  | one-cycle completion pulse
module avgpool_seq #(
  parameter int WORD_SIZE = 16,
  parameter int IN_W      = 28,
  parameter int IN_H      = 28,
  parameter int ADDR_W    = 10,
  parameter int IN_BASE   = 0,
  parameter int OUT_BASE  = 0
) (
  input  logic      clk,
  input  logic      reset,
  avgpool_if.master bus
);
  localparam int COLS = IN_W / 2;
  localparam int ROWS = IN_H / 2;
  localparam int AW   = WORD_SIZE + 2;

  localparam logic [ADDR_W-1:0] A_ROW  = ADDR_W'(2 * IN_W);
  localparam logic [ADDR_W-1:0] A_W    = ADDR_W'(IN_W);
  localparam logic [ADDR_W-1:0] A_W1   = ADDR_W'(IN_W + 1);
  localparam logic [ADDR_W-1:0] A_IN   = ADDR_W'(IN_BASE);
  localparam logic [ADDR_W-1:0] A_OUT  = ADDR_W'(OUT_BASE);
  localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] R_LAST = ADDR_W'(ROWS - 1);

  typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RD3, WR, DONE} state_t;

  state_t                 state;
  logic [ADDR_W-1:0]      r, c;
  logic [ADDR_W-1:0]      a0, row_base, out_addr;
  logic [ADDR_W-1:0]      rd_addr_q;
  logic                   busy_q, done_q;
  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   ext;
  logic signed [AW-1:0]   sum;

  always_comb begin
    ext = {{2{bus.rd_data[WORD_SIZE-1]}}, bus.rd_data};
`ifdef AVGPOOL_ROUND_EN
    sum = acc + ext + AW'(2);
`else
    sum = acc + ext;
`endif
    bus.wr_en   = (state == WR);
    bus.wr_addr = (state == WR) ? out_addr : '0;
    bus.wr_data = (state == WR) ? WORD_SIZE'(sum >>> 2) : '0;
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_addr = rd_addr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      r         <= '0;
      c         <= '0;
      a0        <= '0;
      row_base  <= '0;
      out_addr  <= '0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      acc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= RD0;
            r         <= '0;
            c         <= '0;
            acc       <= '0;
            a0        <= A_IN;
            row_base  <= A_IN;
            out_addr  <= A_OUT;
            rd_addr_q <= A_IN;
            busy_q    <= 1'b1;
          end
        end
        RD0: begin
          rd_addr_q <= a0 + ADDR_W'(1);
          state     <= RD1;
        end
        RD1: begin
          acc       <= ext;
          rd_addr_q <= a0 + A_W;
          state     <= RD2;
        end
        RD2: begin
          acc       <= acc + ext;
          rd_addr_q <= a0 + A_W1;
          state     <= RD3;
        end
        RD3: begin
          acc   <= acc + ext;
          state <= WR;
        end
        WR: begin
          out_addr <= out_addr + ADDR_W'(1);
          if (r == R_LAST && c == C_LAST) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else if (c == C_LAST) begin
            // Window rows are two input rows apart; odd trailing column is skipped here.
            c         <= '0;
            r         <= r + ADDR_W'(1);
            row_base  <= row_base + A_ROW;
            a0        <= row_base + A_ROW;
            rd_addr_q <= row_base + A_ROW;
            state     <= RD0;
          end else begin
            c         <= c + ADDR_W'(1);
            a0        <= a0 + ADDR_W'(2);
            rd_addr_q <= a0 + ADDR_W'(2);
            state     <= RD0;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_avgpool_seq.sv
// Self-checking bench for avgpool_seq: four instances (4x4, 2x2, 5x3 with offset bases, 28x28)
// each backed by a RAM model, checked against an integer-arithmetic pooling reference.
module tb_avgpool_seq;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  avgpool_if #(.WORD_SIZE(16), .ADDR_W(10)) b4 ();
  avgpool_if #(.WORD_SIZE(16), .ADDR_W(10)) b2 ();
  avgpool_if #(.WORD_SIZE(16), .ADDR_W(10)) b5 ();
  avgpool_if #(.WORD_SIZE(16), .ADDR_W(10)) b28 ();

  avgpool_seq #(.IN_W(4), .IN_H(4)) u4 (.clk(clk), .reset(reset), .bus(b4));
  avgpool_seq #(.IN_W(2), .IN_H(2)) u2 (.clk(clk), .reset(reset), .bus(b2));
  avgpool_seq #(.IN_W(5), .IN_H(3), .IN_BASE(8), .OUT_BASE(100)) u5 (.clk(clk), .reset(reset), .bus(b5));
  avgpool_seq u28 (.clk(clk), .reset(reset), .bus(b28));

  logic signed [15:0] m4 [1024];
  logic signed [15:0] m2 [1024];
  logic signed [15:0] m5 [1024];
  logic signed [15:0] m28 [1024];

  typedef struct {int addr; int data;} wr_t;
  wr_t q4[$], q2[$], q5[$], q28[$];
  int  dn4 = 0, dn2 = 0, dn5 = 0, dn28 = 0;
  bit  rd5 [1024];

  int checks = 0;
  int passed = 0;

  // Synchronous-read RAM models
  always @(posedge clk) begin
    b4.rd_data  <= m4[b4.rd_addr];
    b2.rd_data  <= m2[b2.rd_addr];
    b5.rd_data  <= m5[b5.rd_addr];
    b28.rd_data <= m28[b28.rd_addr];
  end

  always @(negedge clk) begin
    if (b4.wr_en)  q4.push_back('{int'(b4.wr_addr), int'(b4.wr_data)});
    if (b2.wr_en)  q2.push_back('{int'(b2.wr_addr), int'(b2.wr_data)});
    if (b5.wr_en)  q5.push_back('{int'(b5.wr_addr), int'(b5.wr_data)});
    if (b28.wr_en) q28.push_back('{int'(b28.wr_addr), int'(b28.wr_data)});
    if (b4.done)  dn4++;
    if (b2.done)  dn2++;
    if (b5.done)  dn5++;
    if (b28.done) dn28++;
    if (b5.busy)  rd5[b5.rd_addr] = 1'b1;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int avg4(input int a, input int b, input int c, input int d);
    int s;
    s = a + b + c + d;
`ifdef AVGPOOL_ROUND_EN
    s = s + 2;
`endif
    if (s >= 0) return s / 4;
    return -((-s + 3) / 4);
  endfunction

  function automatic int mem_rd(input int id, input int a);
    case (id)
      4:       return int'(m4[a]);
      2:       return int'(m2[a]);
      5:       return int'(m5[a]);
      default: return int'(m28[a]);
    endcase
  endfunction

  function automatic int qsize(input int id);
    case (id)
      4:       return q4.size();
      2:       return q2.size();
      5:       return q5.size();
      default: return q28.size();
    endcase
  endfunction

  function automatic wr_t wr_at(input int id, input int k);
    case (id)
      4:       return q4[k];
      2:       return q2[k];
      5:       return q5[k];
      default: return q28[k];
    endcase
  endfunction

  function automatic logic done_of(input int id);
    case (id)
      4:       return b4.done;
      2:       return b2.done;
      5:       return b5.done;
      default: return b28.done;
    endcase
  endfunction

  function automatic int done_cnt(input int id);
    case (id)
      4:       return dn4;
      2:       return dn2;
      5:       return dn5;
      default: return dn28;
    endcase
  endfunction

  task automatic set_start(input int id, input logic v);
    case (id)
      4:       b4.start = v;
      2:       b2.start = v;
      5:       b5.start = v;
      default: b28.start = v;
    endcase
  endtask

  // Pulses start and counts cycles from the start cycle through the done cycle, inclusive.
  task automatic go(input int id, input int budget, input bit repulse, output int cyc);
    @(negedge clk);
    set_start(id, 1'b1);
    @(negedge clk);
    set_start(id, 1'b0);
    cyc = 2;
    while (!done_of(id) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      set_start(id, repulse && (cyc == 7));
    end
    set_start(id, 1'b0);
    chk("done_seen", longint'(done_of(id)), 1);
  endtask

  task automatic check_run(input int id, input int w, input int h, input int ibase,
                           input int obase, input int qs, input string tag);
    int n;
    int got;
    n   = (w / 2) * (h / 2);
    got = qsize(id) - qs;
    chk({tag, "_nwr"}, got, n);
    for (int k = 0; k < n && k < got; k++) begin
      wr_t e;
      int  r, c, a0, exp;
      e   = wr_at(id, qs + k);
      r   = k / (w / 2);
      c   = k % (w / 2);
      a0  = ibase + 2 * r * w + 2 * c;
      exp = avg4(mem_rd(id, a0), mem_rd(id, a0 + 1), mem_rd(id, a0 + w), mem_rd(id, a0 + w + 1));
      chk({tag, "_addr"}, e.addr, obase + k);
      chk({tag, "_data"}, e.data, exp);
    end
  endtask

  initial begin
    int cyc, qs, d0;
    int win [7][4];

    reset = 1'b1;
    b4.start = 1'b0; b2.start = 1'b0; b5.start = 1'b0; b28.start = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      m4[i] = '0; m2[i] = '0; m5[i] = '0; m28[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_busy",    b4.busy, 0);
    chk("rst_done",    b4.done, 0);
    chk("rst_wr_en",   b4.wr_en, 0);
    chk("rst_rd_addr", b4.rd_addr, 0);
    chk("rst_wr_addr", b4.wr_addr, 0);
    chk("rst_wr_data", b4.wr_data, 0);
    reset = 1'b0;
    @(negedge clk);

    // 4x4 ramp: expected 2,4,10,12 with floor
    for (int i = 0; i < 16; i++) m4[i] = 16'(i);
    qs = qsize(4); d0 = done_cnt(4);
    go(4, 100, 1'b0, cyc);
    chk("ramp_cycles", cyc, 22);
    check_run(4, 4, 4, 0, 0, qs, "ramp");

    // Back-to-back random run with start re-pulsed while busy
    for (int i = 0; i < 16; i++) m4[i] = 16'($urandom);
    qs = qsize(4);
    go(4, 100, 1'b1, cyc);
    chk("repulse_cycles", cyc, 22);
    check_run(4, 4, 4, 0, 0, qs, "rnd4");
    @(negedge clk);
    chk("rnd4_done_cnt", done_cnt(4) - d0, 2);
    chk("rnd4_busy_after", b4.busy, 0);
    repeat (4) @(negedge clk);
    chk("repulse_no_restart", b4.busy, 0);

    // Abort after the 2nd write
    qs = qsize(4); d0 = done_cnt(4);
    @(negedge clk);
    b4.start = 1'b1;
    @(negedge clk);
    b4.start = 1'b0;
    for (int i = 0; i < 100 && qsize(4) < qs + 2; i++) @(negedge clk);
    chk("abort_two_writes", qsize(4) - qs, 2);
    reset = 1'b1;
    #1;
    chk("abort_busy",    b4.busy, 0);
    chk("abort_wr_en",   b4.wr_en, 0);
    chk("abort_rd_addr", b4.rd_addr, 0);
    chk("abort_wr_data", b4.wr_data, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort_no_more_wr", qsize(4) - qs, 2);
    chk("abort_no_done", done_cnt(4) - d0, 0);
    for (int i = 0; i < 16; i++) m4[i] = 16'($urandom);
    qs = qsize(4);
    go(4, 100, 1'b0, cyc);
    chk("post_abort_cycles", cyc, 22);
    check_run(4, 4, 4, 0, 0, qs, "post_abort");

    // 2x2 windows: sum -6, saturating extremes, then random
    win[0] = '{-1, -2, -1, -2};
    win[1] = '{32767, 32767, 32767, 32767};
    win[2] = '{-32768, -32768, -32768, -32768};
    for (int t = 3; t < 7; t++)
      for (int j = 0; j < 4; j++) win[t][j] = int'($signed(16'($urandom)));
    for (int t = 0; t < 7; t++) begin
      for (int j = 0; j < 4; j++) m2[j] = 16'(win[t][j]);
      qs = qsize(2);
      go(2, 50, 1'b0, cyc);
      chk("win_cycles", cyc, 7);
      check_run(2, 2, 2, 0, 0, qs, "win");
      if (t == 0 && qsize(2) > qs) begin
`ifdef AVGPOOL_ROUND_EN
        chk("neg6", wr_at(2, qs).data, -1);
`else
        chk("neg6", wr_at(2, qs).data, -2);
`endif
      end
      if (t == 6) begin
        // start coincident with done must be ignored
        b2.start = 1'b1;
        @(negedge clk);
        b2.start = 1'b0;
        chk("start_at_done_ign", b2.busy, 0);
        @(negedge clk);
        chk("start_at_done_ign2", b2.busy, 0);
      end
    end

    // Odd 5x3 map at IN_BASE 8, OUT_BASE 100
    for (int i = 0; i < 1024; i++) m5[i] = 16'($urandom);
    qs = qsize(5); d0 = done_cnt(5);
    go(5, 60, 1'b0, cyc);
    chk("odd_cycles", cyc, 12);
    chk("odd_busy_in_done", b5.busy, 1);
    check_run(5, 5, 3, 8, 100, qs, "odd");
    @(negedge clk);
    chk("odd_busy_after", b5.busy, 0);
    chk("odd_done_after", b5.done, 0);
    chk("odd_done_cnt", done_cnt(5) - d0, 1);
    for (int row = 0; row < 3; row++)
      for (int col = 0; col < 5; col++)
        chk($sformatf("odd_rd_r%0dc%0d", row, col), rd5[8 + row * 5 + col], (row < 2 && col < 4) ? 1 : 0);

    // Default 28x28 random map
    for (int i = 0; i < 784; i++) m28[i] = 16'($urandom);
    qs = qsize(28);
    go(28, 1200, 1'b0, cyc);
    chk("full_cycles", cyc, 982);
    check_run(28, 28, 28, 0, 0, qs, "full");
    @(negedge clk);
    chk("full_busy_after", b28.busy, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
